// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU with handshaked instruction and data memory ports.
// Defining HACK_CPU_HALT_EN adds a HALT state entered on a tight self-loop jump.
module hack_cpu_mc #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic              retire,
  output logic              halted
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    MREAD  = 3'd2,
    EXEC   = 3'd3,
    MWRITE = 3'd4
`ifdef HACK_CPU_HALT_EN
    , HALT = 3'd5
`endif
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   pc_reg;
  logic [DATA_W-1:0]   a_reg, d_reg, mreg_reg, alu_q_reg;
  logic [15:0]         ir_reg;
  logic                jmp_q_reg, retire_reg;

  logic [DATA_W-1:0]   x0, x1, y_src, y0, y1, f_out, alu_res, commit_res;
  logic                zr, ng, jmp, commit, commit_jmp;
  logic [ADDR_W-1:0]   pc_inc;

  // ALU: x is always D, y is M when the a-bit is set, otherwise A
  assign y_src   = ir_reg[12] ? mreg_reg : a_reg;
  assign x0      = ir_reg[11] ? '0 : d_reg;
  assign x1      = ir_reg[10] ? ~x0 : x0;
  assign y0      = ir_reg[9]  ? '0 : y_src;
  assign y1      = ir_reg[8]  ? ~y0 : y0;
  assign f_out   = ir_reg[7]  ? (x1 + y1) : (x1 & y1);
  assign alu_res = ir_reg[6]  ? ~f_out : f_out;
  assign zr      = (alu_res == '0);
  assign ng      = alu_res[DATA_W-1];
  assign jmp     = (ng & ir_reg[2]) | (zr & ir_reg[1]) | (~ng & ~zr & ir_reg[0]);

  // A memory write defers the commit, so the result and jump decision are held
  assign commit     = ((state_reg == EXEC) && !ir_reg[3]) || ((state_reg == MWRITE) && dmem_ack);
  assign commit_res = (state_reg == MWRITE) ? alu_q_reg : alu_res;
  assign commit_jmp = (state_reg == MWRITE) ? jmp_q_reg : jmp;
  assign pc_inc     = pc_reg + ADDR_W'(1);

`ifdef HACK_CPU_HALT_EN
  logic halt_hit;
  assign halt_hit = (state_reg == EXEC) && (ir_reg[2:0] == 3'b111) && !ir_reg[3]
                    && (a_reg[ADDR_W-1:0] == pc_reg);
  assign halted   = (state_reg == HALT);
`else
  assign halted   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= FETCH;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH:  if (imem_ack) state_next = DECODE;
      DECODE: begin
        if (!ir_reg[15])     state_next = FETCH;
        else if (ir_reg[12]) state_next = MREAD;
        else                 state_next = EXEC;
      end
      MREAD:  if (dmem_ack) state_next = EXEC;
      EXEC: begin
        if (ir_reg[3])     state_next = MWRITE;
`ifdef HACK_CPU_HALT_EN
        else if (halt_hit) state_next = HALT;
`endif
        else               state_next = FETCH;
      end
      MWRITE: if (dmem_ack) state_next = FETCH;
      default: state_next = state_reg;
    endcase
  end

  // Requests are also gated by reset so an abort drops them without waiting for a clock
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    if (!reset) begin
      case (state_reg)
        FETCH:  imem_req = 1'b1;
        MREAD:  dmem_req = 1'b1;
        MWRITE: begin
          dmem_req = 1'b1;
          dmem_we  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg     <= '0;
      a_reg      <= '0;
      d_reg      <= '0;
      ir_reg     <= '0;
      mreg_reg   <= '0;
      alu_q_reg  <= '0;
      jmp_q_reg  <= 1'b0;
      retire_reg <= 1'b0;
    end else begin
      retire_reg <= 1'b0;
      case (state_reg)
        FETCH:  if (imem_ack) ir_reg <= imem_data;
        DECODE: if (!ir_reg[15]) begin
          a_reg      <= {{(DATA_W-15){1'b0}}, ir_reg[14:0]};
          pc_reg     <= pc_inc;
          retire_reg <= 1'b1;
        end
        MREAD:  if (dmem_ack) mreg_reg <= dmem_rdata;
        EXEC:   if (ir_reg[3]) begin
          alu_q_reg <= alu_res;
          jmp_q_reg <= jmp;
        end
        default: ;
      endcase
      if (commit) begin
        if (ir_reg[4]) d_reg <= commit_res;
        if (ir_reg[5]) a_reg <= commit_res;
        pc_reg     <= commit_jmp ? a_reg[ADDR_W-1:0] : pc_inc;
        retire_reg <= 1'b1;
      end
    end
  end

  assign imem_addr  = pc_reg;
  assign pc         = pc_reg;
  assign dmem_addr  = a_reg[ADDR_W-1:0];
  assign dmem_wdata = alu_q_reg;
  assign retire     = retire_reg;

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Directed bench for hack_cpu_mc: program table plus hand-written abort, wrap and loop sequences.
// Halt checks run only when HACK_CPU_HALT_EN is defined.
module tb_hack_cpu_mc;
  localparam int DW = 16;
  localparam int AW = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retire, halted;
  logic [AW-1:0] imem_addr, dmem_addr, pc;
  logic [15:0]   imem_data;
  logic [DW-1:0] dmem_wdata, dmem_rdata;

  hack_cpu_mc #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc(pc), .retire(retire), .halted(halted)
  );

  // Second core with a 4-bit pc for the wrap-around check
  logic        s_imem_req, s_imem_ack, s_dmem_req, s_dmem_we, s_dmem_ack, s_retire, s_halted;
  logic [3:0]  s_imem_addr, s_dmem_addr, s_pc;
  logic [15:0] s_imem_data, s_dmem_wdata;
  logic [15:0] srom [16];

  hack_cpu_mc #(.DATA_W(16), .ADDR_W(4)) dut_s (
    .clk(clk), .reset(reset),
    .imem_req(s_imem_req), .imem_addr(s_imem_addr), .imem_ack(s_imem_ack), .imem_data(s_imem_data),
    .dmem_req(s_dmem_req), .dmem_we(s_dmem_we), .dmem_addr(s_dmem_addr), .dmem_wdata(s_dmem_wdata),
    .dmem_ack(s_dmem_ack), .dmem_rdata(16'h0000),
    .pc(s_pc), .retire(s_retire), .halted(s_halted)
  );
  assign s_imem_ack  = s_imem_req;
  assign s_imem_data = srom[s_imem_addr];
  assign s_dmem_ack  = s_dmem_req;

  // Memory model with configurable wait states; writes are logged, not stored
  logic [15:0]   rom [64];
  logic [DW-1:0] ram2;
  int            iwait_cfg = 0, dwait_cfg = 0;
  int            icnt = 0, dcnt = 0, wr_count = 0, dreq_cycles = 0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;

  assign imem_ack   = imem_req && (icnt >= iwait_cfg);
  assign dmem_ack   = dmem_req && (dcnt >= dwait_cfg);
  assign imem_data  = (imem_addr < AW'(64)) ? rom[imem_addr[5:0]] : 16'h0000;
  assign dmem_rdata = (dmem_addr == AW'(2)) ? ram2 : '0;

  always @(posedge clk) begin
    icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
    dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
    if (dmem_req) dreq_cycles <= dreq_cycles + 1;
    if (dmem_req && dmem_we && dmem_ack) begin
      wr_count <= wr_count + 1;
      wr_addr  <= dmem_addr;
      wr_data  <= dmem_wdata;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  typedef struct {
    string       name;
    logic [15:0] p0, p1, p2, p3;
    int          n, iwait, dwait;
    logic [15:0] r2;
    int          cycles;
    logic [15:0] epc, ea, ed;
    int          writes;
    logic [15:0] waddr, wdata;
    int          dreq;
  } vec_t;

  function automatic vec_t mk(string nm, logic [15:0] p0, logic [15:0] p1, logic [15:0] p2,
                              logic [15:0] p3, int n, int iw, int dwt, logic [15:0] r2, int cyc,
                              logic [15:0] epc, logic [15:0] ea, logic [15:0] ed, int wr,
                              logic [15:0] wa, logic [15:0] wd, int dq);
    vec_t v;
    v.name = nm; v.p0 = p0; v.p1 = p1; v.p2 = p2; v.p3 = p3;
    v.n = n; v.iwait = iw; v.dwait = dwt; v.r2 = r2; v.cycles = cyc;
    v.epc = epc; v.ea = ea; v.ed = ed; v.writes = wr; v.waddr = wa; v.wdata = wd; v.dreq = dq;
    return v;
  endfunction

  task automatic load_and_reset(input logic [15:0] p0, input logic [15:0] p1,
                                input logic [15:0] p2, input logic [15:0] p3,
                                input int iw, input int dwt, input logic [15:0] r2);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
    rom[0] = p0; rom[1] = p1; rom[2] = p2; rom[3] = p3;
    iwait_cfg = iw; dwait_cfg = dwt; ram2 = r2;
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    int edges, rets, wr0, dq0;
    load_and_reset(v.p0, v.p1, v.p2, v.p3, v.iwait, v.dwait, v.r2);
    check({v.name, " reset state"},
          64'(|{pc, imem_req, dmem_req, dmem_we, retire, halted, dmem_wdata,
                dut.a_reg, dut.d_reg, dut.ir_reg}), 64'd0);
    wr0 = wr_count; dq0 = dreq_cycles;
    reset = 1'b0;
    edges = 0; rets = 0;
    while (rets < v.n && edges < 400) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (retire) rets++;
    end
    check({v.name, " retired"}, 64'(rets), 64'(v.n));
    check({v.name, " cycles"}, 64'(edges), 64'(v.cycles));
    check({v.name, " pc"}, 64'(pc), 64'(v.epc));
    check({v.name, " A"}, 64'(dut.a_reg), 64'(v.ea));
    check({v.name, " D"}, 64'(dut.d_reg), 64'(v.ed));
    check({v.name, " writes"}, 64'(wr_count - wr0), 64'(v.writes));
    check({v.name, " dmem_req cycles"}, 64'(dreq_cycles - dq0), 64'(v.dreq));
    if (v.writes > 0) begin
      check({v.name, " write addr"}, 64'(wr_addr), 64'(v.waddr));
      check({v.name, " write data"}, 64'(wr_data), 64'(v.wdata));
    end
  endtask

  vec_t vecs[9];

  initial begin
    int rets, wr0, seen, pc2, pc3, ireqs;
    //                 name          prog                                  n iw dw ram2     cyc pc      A        D        wr wa     wd       dq
    vecs[0] = mk("store5",   16'h0005, 16'hEC10, 16'h0007, 16'hE308, 4, 0, 0, 16'h0000, 11, 16'd4,  16'd7,  16'd5,    1, 16'd7, 16'd5,  1);
    vecs[1] = mk("read_wait",16'h0002, 16'hFC10, 16'h0000, 16'h0000, 2, 0, 3, 16'h1234,  9, 16'd2,  16'd2,  16'h1234, 0, 16'd0, 16'd0,  4);
    vecs[2] = mk("jlt_neg",  16'hEE90, 16'h000A, 16'hE304, 16'h0000, 3, 0, 0, 16'h0000,  8, 16'd10, 16'd10, 16'hFFFF, 0, 16'd0, 16'd0,  0);
    vecs[3] = mk("jgt_zero", 16'hEA90, 16'h000A, 16'hE301, 16'h0000, 3, 0, 0, 16'h0000,  8, 16'd3,  16'd10, 16'd0,    0, 16'd0, 16'd0,  0);
    vecs[4] = mk("jmp",      16'h000A, 16'hEA87, 16'h0000, 16'h0000, 2, 0, 0, 16'h0000,  5, 16'd10, 16'd10, 16'd0,    0, 16'd0, 16'd0,  0);
    vecs[5] = mk("ad_a1_jmp",16'h0003, 16'hEDF7, 16'h0000, 16'h0000, 2, 0, 0, 16'h0000,  5, 16'd3,  16'd4,  16'd4,    0, 16'd0, 16'd0,  0);
    vecs[6] = mk("m_inc",    16'h0002, 16'hFDC8, 16'h0000, 16'h0000, 2, 0, 0, 16'h1234,  7, 16'd2,  16'd2,  16'd0,    1, 16'd2, 16'h1235, 2);
    vecs[7] = mk("and_wwait",16'h000C, 16'hEC10, 16'h0005, 16'hE008, 4, 0, 2, 16'h0000, 13, 16'd4,  16'd5,  16'd12,   1, 16'd5, 16'd4,  3);
    vecs[8] = mk("fetchwait",16'h0005, 16'hEC10, 16'h0007, 16'hE308, 4, 1, 0, 16'h0000, 15, 16'd4,  16'd7,  16'd5,    1, 16'd7, 16'd5,  1);

    for (int i = 0; i < 16; i++) srom[i] = 16'h0000;
    srom[0] = 16'h000F;
    srom[1] = 16'hEA87;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Reset pulsed while a store is waiting for its ack
    load_and_reset(16'h0007, 16'hE308, 16'h0000, 16'h0000, 0, 1000, 16'h0000);
    wr0 = wr_count;
    reset = 1'b0;
    rets = 0; seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (retire) rets++;
      if (dmem_req && dmem_we) seen = 1;
    end
    check("abort reached mwrite", 64'(seen), 64'd1);
    repeat (2) begin
      @(negedge clk);
      if (retire) rets++;
    end
    #2 reset = 1'b1;
    #1 check("abort requests drop", 64'({imem_req, dmem_req, dmem_we}), 64'd0);
    check("abort pc", 64'(pc), 64'd0);
    @(negedge clk);
    check("abort no write", 64'(wr_count - wr0), 64'd0);
    check("abort retires", 64'(rets + int'(retire)), 64'd1);

    // 4-bit pc: jump to 15, then an A-instruction there wraps pc to 0
    @(negedge clk);
    reset = 1'b0;
    rets = 0; pc2 = -1; pc3 = -1;
    for (int i = 0; i < 40 && rets < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (s_retire) begin
        rets++;
        if (rets == 2) pc2 = int'(s_pc);
        if (rets == 3) pc3 = int'(s_pc);
      end
    end
    check("wrap pc after jump", 64'(pc2), 64'd15);
    check("wrap pc after A at 15", 64'(pc3), 64'd0);

    // Self-loop at address 1 targeting 0 never matches the halt condition
    load_and_reset(16'h0000, 16'hEA87, 16'h0000, 16'h0000, 0, 0, 16'h0000);
    reset = 1'b0;
    rets = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (retire) rets++;
    end
    check("loop retires in 50 cycles", 64'(rets), 64'd20);
    check("loop pc", 64'(pc), 64'd0);
    check("loop not halted", 64'(halted), 64'd0);

`ifdef HACK_CPU_HALT_EN
    load_and_reset(16'h0001, 16'hEA87, 16'h0000, 16'h0000, 0, 0, 16'h0000);
    reset = 1'b0;
    rets = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (retire) rets++;
    end
    check("halt after 5 cycles", 64'(halted), 64'd1);
    check("halt retires", 64'(rets), 64'd2);
    ireqs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req) ireqs++;
      if (retire) rets++;
    end
    check("halt no fetch", 64'(ireqs), 64'd0);
    check("halt retires stay", 64'(rets), 64'd2);
`else
    ireqs = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
